// File: rtl/seq_loader.sv
// seq_loader: packs an ASCII nucleotide stream (reference then query) into 2-bit BRAM words
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a load (honoured in IDLE only)
//   in_char/valid/last/ready character stream handshake
//   rwr_*, qwr_*             reference / query BRAM word write ports
//   ref_len, query_len       stored character counts (saturate at TILE_SIZE)
//   done                     one-cycle pulse once both sequences are loaded
//   err_char, err_ovf        sticky non-ACGT / over-length flags
module seq_loader #(
  parameter int TILE_SIZE       = 512,
  parameter int LOG_TILE_SIZE   = $clog2(TILE_SIZE),
  parameter int DATA_WIDTH      = 16,
  parameter int BLOCK_WIDTH     = 8,
  parameter int LOG_BLOCK_WIDTH = $clog2(BLOCK_WIDTH),
  parameter int CHAR_WIDTH      = DATA_WIDTH / BLOCK_WIDTH,
  parameter int ADDR_WIDTH      = LOG_TILE_SIZE - LOG_BLOCK_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              in_char,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    rwr_en,
  output logic [ADDR_WIDTH-1:0]   rwr_addr,
  output logic [DATA_WIDTH-1:0]   rwr_data,
  output logic                    qwr_en,
  output logic [ADDR_WIDTH-1:0]   qwr_addr,
  output logic [DATA_WIDTH-1:0]   qwr_data,
  output logic [LOG_TILE_SIZE:0]  ref_len,
  output logic [LOG_TILE_SIZE:0]  query_len,
  output logic                    done,
  output logic                    err_char,
  output logic                    err_ovf
);
  localparam logic [1:0] IDLE = 2'd0, LOAD_REF = 2'd1, LOAD_QRY = 2'd2, FIN = 2'd3;
  localparam int LW = LOG_TILE_SIZE + 1;
  logic [1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d, wr_data_q, wr_data_d, packed_w;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic rwr_en_q, rwr_en_d, qwr_en_q, qwr_en_d;
  logic [LW-1:0] ref_len_q, ref_len_d, query_len_q, query_len_d, n, n_next;
  logic err_char_q, err_char_d, err_ovf_q, err_ovf_d;
  logic loading, is_ref, acc, stored, bad, wr, clear;
  logic [7:0] uc;
  logic [1:0] code;
  always_comb begin
    // clearing bit 5 folds lower-case letters onto upper-case
    uc = in_char & 8'hDF;
    code = uc == 8'h43 ? 2'd1 : uc == 8'h47 ? 2'd2 : uc == 8'h54 ? 2'd3 : 2'd0;
    bad = !(uc == 8'h41 || uc == 8'h43 || uc == 8'h47 || uc == 8'h54);
    loading = state_q == LOAD_REF || state_q == LOAD_QRY;
    is_ref = state_q == LOAD_REF;
    acc = in_valid && loading;
    clear = state_q == IDLE && start;
    // the running length doubles as the index of the incoming character
    n = is_ref ? ref_len_q : query_len_q;
    stored = n < LW'(TILE_SIZE);
    n_next = stored ? n + 1'b1 : n;
    packed_w = buf_q | (DATA_WIDTH'(code) << (CHAR_WIDTH * n[LOG_BLOCK_WIDTH-1:0]));
    wr = acc && stored && (&n[LOG_BLOCK_WIDTH-1:0] || in_last);
    state_d = state_q == IDLE ? (start ? LOAD_REF : IDLE) :
              state_q == FIN ? IDLE :
              (acc && in_last) ? state_q + 2'd1 : state_q;
    ref_len_d = clear ? '0 : (acc && is_ref) ? n_next : ref_len_q;
    query_len_d = clear ? '0 : (acc && !is_ref) ? n_next : query_len_q;
    err_char_d = !clear && (err_char_q || (acc && bad));
    err_ovf_d = !clear && (err_ovf_q || (acc && !stored));
    buf_d = clear ? '0 : !(acc && stored) ? buf_q : wr ? '0 : packed_w;
    rwr_en_d = wr && is_ref;
    qwr_en_d = wr && !is_ref;
    wr_addr_d = wr ? n[LOG_TILE_SIZE-1:LOG_BLOCK_WIDTH] : wr_addr_q;
    wr_data_d = wr ? packed_w : wr_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      rwr_en_q <= 1'b0;
      qwr_en_q <= 1'b0;
      ref_len_q <= '0;
      query_len_q <= '0;
      err_char_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      rwr_en_q <= rwr_en_d;
      qwr_en_q <= qwr_en_d;
      ref_len_q <= ref_len_d;
      query_len_q <= query_len_d;
      err_char_q <= err_char_d;
      err_ovf_q <= err_ovf_d;
    end
  end
  assign in_ready = loading;
  assign done = state_q == FIN;
  assign rwr_en = rwr_en_q;
  assign qwr_en = qwr_en_q;
  assign rwr_addr = wr_addr_q;
  assign qwr_addr = wr_addr_q;
  assign rwr_data = wr_data_q;
  assign qwr_data = wr_data_q;
  assign ref_len = ref_len_q;
  assign query_len = query_len_q;
  assign err_char = err_char_q;
  assign err_ovf = err_ovf_q;
endmodule

// File: tb/tb_seq_loader.sv
// tb_seq_loader: directed stimulus against a string-level model of the loader
module tb_seq_loader;
  logic clk = 1'b0, rst, start, in_valid, in_last, in_ready;
  logic rwr_en, qwr_en, done, err_char, err_ovf;
  logic [7:0] in_char;
  logic [5:0] rwr_addr, qwr_addr;
  logic [15:0] rwr_data, qwr_data;
  logic [9:0] ref_len, query_len;
  int checks = 0, errors = 0;
  logic [21:0] exp_r[$], exp_q[$];
  int e_rlen, e_qlen, done_cnt = 0, r_wr = 0, q_wr = 0;
  bit e_cerr, e_ovf, e_fin_wr;
  logic [21:0] last_r, last_q;
  always #5 clk = ~clk;
  seq_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_char(in_char), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .rwr_en(rwr_en), .rwr_addr(rwr_addr),
    .rwr_data(rwr_data), .qwr_en(qwr_en), .qwr_addr(qwr_addr), .qwr_data(qwr_data),
    .ref_len(ref_len), .query_len(query_len), .done(done), .err_char(err_char),
    .err_ovf(err_ovf)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic int code_of(input logic [7:0] c);
    string al = "ACGT";
    for (int k = 0; k < 4; k++) begin
      logic [7:0] u = al[k];
      if (c == u || c == (u | 8'h20)) return k;
    end
    return -1;
  endfunction
  function automatic string rep(input string c, input int n);
    string s = "";
    repeat (n) s = {s, c};
    return s;
  endfunction
  task automatic build(input string s, input bit is_ref, output int len);
    logic [15:0] w[64];
    int st, c;
    for (int a = 0; a < 64; a++) w[a] = 16'h0;
    st = s.len() > 512 ? 512 : s.len();
    for (int i = 0; i < s.len(); i++) begin
      c = code_of(s[i]);
      if (c < 0) begin e_cerr = 1; c = 0; end
      if (i < 512) w[i / 8] = w[i / 8] + 16'(c * (1 << (2 * (i % 8))));
    end
    if (s.len() > 512) e_ovf = 1;
    for (int a = 0; a < (st + 7) / 8; a++)
      if (is_ref) exp_r.push_back({6'(a), w[a]});
      else exp_q.push_back({6'(a), w[a]});
    len = st;
  endtask
  task automatic send(input string s, input bit gaps, input bit mid);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && i % 2 == 1) begin
        in_valid = 0;
        start = mid && i == 1;
        @(posedge clk); #1;
        start = 0;
      end
      chk("no_stall", in_ready, 1);
      in_valid = 1;
      in_char = s[i];
      in_last = i == s.len() - 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic run(input string r, input string q, input bit gaps, input bit mid);
    int prev = done_cnt, t = 0;
    e_cerr = 0;
    e_ovf = 0;
    build(r, 1, e_rlen);
    build(q, 0, e_qlen);
    e_fin_wr = q.len() <= 512;
    r_wr = 0;
    q_wr = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    send(r, 0, 0);
    send(q, gaps, mid);
    while (done_cnt == prev && t < 10) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt, prev + 1);
    chk("idle_ready", in_ready, 0);
  endtask
  always @(negedge clk) if (!rst) begin
    if (rwr_en) begin
      r_wr++;
      last_r = {rwr_addr, rwr_data};
      if (exp_r.size() == 0) chk("rwr_extra", 1, 0);
      else chk("rwr_word", last_r, exp_r.pop_front());
    end
    if (qwr_en) begin
      q_wr++;
      last_q = {qwr_addr, qwr_data};
      if (exp_q.size() == 0) chk("qwr_extra", 1, 0);
      else chk("qwr_word", last_q, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      chk("done_with_qwr", qwr_en, e_fin_wr);
      chk("ref_len", ref_len, e_rlen);
      chk("query_len", query_len, e_qlen);
      chk("err_char", err_char, e_cerr);
      chk("err_ovf", err_ovf, e_ovf);
      chk("ref_missing", exp_r.size(), 0);
      chk("qry_missing", exp_q.size(), 0);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int prev;
    rst = 1; start = 0; in_valid = 0; in_char = 0; in_last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_wr", {rwr_en, qwr_en, done}, 0);
    chk("rst_len", {ref_len, query_len}, 0);
    chk("rst_err", {err_char, err_ovf}, 0);
    rst = 0;
    run("ACGTACGT", "TTGA", 0, 0);
    chk("t1_ref_word", last_r, {6'd0, 16'hE4E4});
    chk("t1_qry_word", last_q, {6'd0, 16'h002F});
    chk("t1_lens", {ref_len, query_len}, {10'd8, 10'd4});
    run(rep("C", 17), "A", 0, 0);
    chk("t2_ref_last", last_r, {6'd2, 16'h0001});
    chk("t2_ref_count", r_wr, 3);
    chk("t2_ref_len", ref_len, 17);
    run("ANGT", "ag", 0, 0);
    chk("t3_ref_word", last_r, {6'd0, 16'h00E0});
    chk("t3_err_char", err_char, 1);
    run(rep("G", 520), "ACGT", 0, 0);
    chk("t4_ref_count", r_wr, 64);
    chk("t4_ref_last", last_r, {6'd63, 16'hAAAA});
    chk("t4_ref_len", ref_len, 512);
    chk("t4_ovf", err_ovf, 1);
    chk("t4_err_char", err_char, 0);
    run("ACGTACGT", "TTGA", 1, 1);
    chk("t5_qry_word", last_q, {6'd0, 16'h002F});
    chk("t5_lens", {ref_len, query_len}, {10'd8, 10'd4});
    prev = done_cnt;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_char = "C"; in_last = 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_len", ref_len, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_done", done_cnt, prev);
    run("T", "A", 0, 0);
    chk("t6_ref_word", last_r, {6'd0, 16'h0003});
    chk("t6_qry_word", last_q, {6'd0, 16'h0000});
    chk("t6_writes", {r_wr[7:0], q_wr[7:0]}, 16'h0101);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
